riscv_issue_ctl: RTL and testbench

//  Issue/interlock controller in front of riscv_ex. Decides each cycle whether the decoded

---
 rtl/riscv_issue_ctl.sv | 124 ++++++++++++
 tb/tb_riscv_issue_ctl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/riscv_issue_ctl.sv
// riscv_issue_ctl
//   Issue/interlock controller between decode and riscv_ex. It decides whether the
//   decoded instruction may enter EX this cycle, selects the operand-forwarding
//   source for the a/b muxes, and tracks outstanding loads in a register scoreboard
//   so that load-use hazards stall instead of reading stale data.
//
// Ports
//   rst, clk              asynchronous active-high reset, rising-edge clock
//   id_valid              decode presents an instruction
//   id_rs1/id_rs2         source registers, qualified by id_use_rs1/id_use_rs2
//   id_rd, id_is_load     destination register; instruction is a load
//   flush                 squash the current decode slot (branch redirect)
//   wb_valid, wb_rd       a load result returns this cycle for register wb_rd
//   issue                 instruction accepted into EX this cycle
//   stall                 decode must hold its instruction
//   fwd_a/fwd_b           operand source: 0 regfile, 1 EX result, 2 wb data
//   load_cnt              number of outstanding loads
//   busy                  loads outstanding or an instruction in EX
module riscv_issue_ctl #(
  parameter int unsigned MAX_LOADS = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             issue,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] load_cnt,
  output logic             busy
);

  logic [31:0] pend;
  logic [31:0] pend_next;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_load;
  logic        haz_a;
  logic        haz_b;
  logic        load_full;
  logic        cnt_inc;
  logic        cnt_dec;

  // Returns {hazard, fwd} for one source operand, applying the bypass priority:
  // ALU result in EX, load in EX, load returning this cycle, load still pending.
  function automatic logic [2:0] resolve(
    input logic        use_s,
    input logic [4:0]  s,
    input logic        ev,
    input logic        el,
    input logic [4:0]  erd,
    input logic [31:0] pnd,
    input logic        wv,
    input logic [4:0]  wrd
  );
    logic [2:0] r;
    r = '0;
    if (use_s && (s != 5'd0)) begin
      if (ev && !el && (erd == s))      r = 3'b001;
      else if (ev && el && (erd == s))  r = 3'b100;
      else if (pnd[s] && wv && (wrd == s)) r = 3'b010;
      else if (pnd[s])                  r = 3'b100;
      else                              r = 3'b000;
    end
    return r;
  endfunction

  always_comb begin
    {haz_a, fwd_a} = resolve(id_use_rs1, id_rs1, ex_valid, ex_load, ex_rd, pend, wb_valid, wb_rd);
    {haz_b, fwd_b} = resolve(id_use_rs2, id_rs2, ex_valid, ex_load, ex_rd, pend, wb_valid, wb_rd);
  end

  assign load_full = (load_cnt == CNT_W'(MAX_LOADS));
  assign stall     = id_valid && !flush && (haz_a || haz_b || (id_is_load && load_full));
  assign issue     = id_valid && !flush && !stall;
  assign busy      = (load_cnt != '0) || ex_valid;

  assign cnt_inc   = issue && id_is_load;
  // A return with nothing outstanding is ignored so the counter cannot wrap.
  assign cnt_dec   = wb_valid && (load_cnt != '0);

  // Clear on return first, then set on load issue, so a same-register
  // return and re-issue in one cycle leaves the entry pending.
  always_comb begin
    pend_next = pend;
    if (wb_valid)
      pend_next[wb_rd] = 1'b0;
    if (issue && id_is_load && (id_rd != 5'd0))
      pend_next[id_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      ex_load  <= 1'b0;
      load_cnt <= '0;
    end else begin
      pend     <= pend_next;
      ex_valid <= issue;
      if (issue) begin
        ex_rd   <= id_rd;
        ex_load <= id_is_load;
      end
      if (cnt_inc && !cnt_dec)
        load_cnt <= load_cnt + CNT_W'(1);
      else if (cnt_dec && !cnt_inc)
        load_cnt <= load_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_riscv_issue_ctl.sv
// Directed bench for riscv_issue_ctl. The driver applies one decode/writeback
// vector per cycle and queues the hand-computed response; the monitor samples
// on the falling edge and compares against the queue head.
module tb_riscv_issue_ctl;

  logic       rst;
  logic       clk;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_is_load;
  logic       flush;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       issue;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [2:0] load_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string nm;
    logic  is;
    logic  st;
    int    fa;   // -1: not checked
    int    fb;   // -1: not checked
    int    cnt;
    logic  bsy;
  } exp_t;

  exp_t q[$];

  riscv_issue_ctl #(.MAX_LOADS(4), .CNT_W(3)) dut (
    .rst(rst), .clk(clk), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_is_load(id_is_load), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue(issue), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .load_cnt(load_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s.%s got %0d want %0d", nm, fld, got, want);
    end
  endtask

  // Monitor: outputs are settled at the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "issue", int'(issue), int'(e.is));
      chk(e.nm, "stall", int'(stall), int'(e.st));
      if (e.fa >= 0) chk(e.nm, "fwd_a", int'(fwd_a), e.fa);
      if (e.fb >= 0) chk(e.nm, "fwd_b", int'(fwd_b), e.fb);
      chk(e.nm, "load_cnt", int'(load_cnt), e.cnt);
      chk(e.nm, "busy", int'(busy), int'(e.bsy));
    end
  end

  // One cycle: apply a vector just after the rising edge and queue its expectation.
  task automatic cyc(
    input string nm,
    input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
    input logic [4:0] rd, input logic ld, input logic fl, input logic wv, input logic [4:0] wrd,
    input logic e_is, input logic e_st, input int e_fa, input int e_fb, input int e_cnt,
    input logic e_bsy
  );
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v;   id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd;     id_is_load = ld; flush = fl;   wb_valid = wv; wb_rd = wrd;
    e.nm = nm; e.is = e_is; e.st = e_st; e.fa = e_fa; e.fb = e_fb; e.cnt = e_cnt; e.bsy = e_bsy;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; id_rs1 = 0; id_use_rs1 = 0; id_rs2 = 0; id_use_rs2 = 0;
    id_rd = 0; id_is_load = 0; flush = 0; wb_valid = 0; wb_rd = 0;

    //   name        v rs1 u1 rs2 u2 rd ld fl wv wrd   is st  fa  fb cnt busy
    cyc("reset",     0, 0, 0, 0, 0,  0, 0, 0, 0, 0,    0, 0,  0,  0, 0, 0);
    @(posedge clk); #1; rst = 1'b0;
    // ALU -> ALU bypass
    cyc("alu_rd4",   1, 0, 0, 0, 0,  4, 0, 0, 0, 0,    1, 0, -1, -1, 0, 0);
    cyc("use_rs4",   1, 4, 1, 0, 0,  8, 0, 0, 0, 0,    1, 0,  1, -1, 0, 1);
    cyc("idle0",     0, 0, 0, 0, 0,  0, 0, 0, 0, 0,    0, 0, -1, -1, 0, 1);
    // Load-use: stall two cycles, then forward from writeback
    cyc("ld_rd5",    1, 0, 0, 0, 0,  5, 1, 0, 0, 0,    1, 0, -1, -1, 0, 0);
    cyc("lu_st1",    1, 0, 0, 5, 1,  9, 0, 0, 0, 0,    0, 1, -1, -1, 1, 1);
    cyc("lu_st2",    1, 0, 0, 5, 1,  9, 0, 0, 0, 0,    0, 1, -1, -1, 1, 1);
    cyc("lu_wb",     1, 0, 0, 5, 1,  9, 0, 0, 1, 5,    1, 0, -1,  2, 1, 1);
    cyc("idle1",     0, 0, 0, 0, 0,  0, 0, 0, 0, 0,    0, 0, -1, -1, 0, 1);
    cyc("p5_clear",  1, 0, 0, 5, 1,  0, 0, 0, 0, 0,    1, 0, -1,  0, 0, 0);
    // Fill to MAX_LOADS outstanding
    cyc("ld1",       1, 0, 0, 0, 0,  1, 1, 0, 0, 0,    1, 0, -1, -1, 0, 1);
    cyc("ld2",       1, 0, 0, 0, 0,  2, 1, 0, 0, 0,    1, 0, -1, -1, 1, 1);
    cyc("ld3",       1, 0, 0, 0, 0,  3, 1, 0, 0, 0,    1, 0, -1, -1, 2, 1);
    cyc("ld4",       1, 0, 0, 0, 0,  4, 1, 0, 0, 0,    1, 0, -1, -1, 3, 1);
    cyc("ld5_full",  1, 0, 0, 0, 0, 10, 1, 0, 0, 0,    0, 1, -1, -1, 4, 1);
    cyc("alu_rs7",   1, 7, 1, 0, 0, 11, 0, 0, 0, 0,    1, 0,  0, -1, 4, 1);
    cyc("ld5_wb1",   1, 0, 0, 0, 0, 10, 1, 0, 1, 1,    0, 1, -1, -1, 4, 1);
    cyc("ld5_go",    1, 0, 0, 0, 0, 10, 1, 0, 0, 0,    1, 0, -1, -1, 3, 1);
    cyc("wb2",       0, 0, 0, 0, 0,  0, 0, 0, 1, 2,    0, 0, -1, -1, 4, 1);
    cyc("wb3",       0, 0, 0, 0, 0,  0, 0, 0, 1, 3,    0, 0, -1, -1, 3, 1);
    cyc("wb4",       0, 0, 0, 0, 0,  0, 0, 0, 1, 4,    0, 0, -1, -1, 2, 1);
    cyc("wb10",      0, 0, 0, 0, 0,  0, 0, 0, 1, 10,   0, 0, -1, -1, 1, 1);
    // Same-cycle return and re-issue on rd=6: entry stays pending, count unchanged
    cyc("ld6",       1, 0, 0, 0, 0,  6, 1, 0, 0, 0,    1, 0, -1, -1, 0, 0);
    cyc("idle2",     0, 0, 0, 0, 0,  0, 0, 0, 0, 0,    0, 0, -1, -1, 1, 1);
    cyc("ld6_wb6",   1, 0, 0, 0, 0,  6, 1, 0, 1, 6,    1, 0, -1, -1, 1, 1);
    cyc("cnt_same",  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,    0, 0, -1, -1, 1, 1);
    cyc("p6_set",    1, 6, 1, 0, 0,  0, 0, 0, 0, 0,    0, 1, -1, -1, 1, 1);
    cyc("p6_wb",     1, 6, 1, 0, 0,  0, 0, 0, 1, 6,    1, 0,  2, -1, 1, 1);
    // x0 is never a hazard, even behind a load to x0
    cyc("ld_rd0",    1, 0, 0, 0, 0,  0, 1, 0, 0, 0,    1, 0, -1, -1, 0, 1);
    cyc("rs1_x0",    1, 0, 1, 0, 0, 12, 0, 0, 0, 0,    1, 0,  0, -1, 1, 1);
    cyc("wb_x0",     0, 0, 0, 0, 0,  0, 0, 0, 1, 0,    0, 0, -1, -1, 1, 1);
    // Flush masks a pending hazard
    cyc("ld13",      1, 0, 0, 0, 0, 13, 1, 0, 0, 0,    1, 0, -1, -1, 0, 0);
    cyc("flush_hz",  1,13, 1, 0, 0,  0, 0, 1, 0, 0,    0, 0, -1, -1, 1, 1);
    cyc("p13_hz",    1,13, 1, 0, 0,  0, 0, 0, 0, 0,    0, 1, -1, -1, 1, 1);
    // Asynchronous reset with a load outstanding clears the scoreboard and count
    @(posedge clk); #1; rst = 1'b1;
    cyc("rst_mid",   0, 0, 0, 0, 0,  0, 0, 0, 0, 0,    0, 0, -1, -1, 0, 0);
    @(posedge clk); #1; rst = 1'b0;
    cyc("p13_gone",  1,13, 1, 0, 0,  0, 0, 0, 0, 0,    1, 0,  0, -1, 0, 0);
    cyc("wb_drop",   0, 0, 0, 0, 0,  0, 0, 0, 1, 13,   0, 0, -1, -1, 0, 1);
    cyc("no_undflw", 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,    0, 0, -1, -1, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
